// File: rtl/cell_feeder_pkg.sv
// cell_feeder_pkg
//   Shared types and constants for the cell byte feeder.
//   - feeder_state_t : FSM state encoding (IDLE, READ, EMIT)
//   - CELLS_H/CELLS_V: display grid, CELL_COUNT_DEFAULT cells per full screen
//   - width_for()    : counter width able to hold 0..max_value (never 0)
package cell_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EMIT = 2'd2
   } feeder_state_t;

   localparam int CELLS_H            = 36;
   localparam int CELLS_V            = 20;
   localparam int CELL_COUNT_DEFAULT = CELLS_H * CELLS_V;

   // Width of an unsigned counter that must reach max_value. A 1-bit
   // floor keeps degenerate parameter choices from producing zero-width
   // vectors.
   function automatic int width_for(input int max_value);
      int w;
      w = $clog2(max_value + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   Conditions a raw active-low push-button into a clean level and a
//   single-cycle press pulse.
//   Ports:
//     clk   in  1  system clock
//     rst   in  1  asynchronous, active-high reset
//     raw_n in  1  raw button, active-low, asynchronous to clk
//     level out 1  debounced button level (1 = released)
//     press out 1  one-cycle pulse on each 1->0 change of level
//   Timing: a raw fall held long enough shows up on press after
//   2 synchronizer cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
module button_debouncer
   import cell_feeder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_n,
   output logic level,
   output logic press
);

   localparam int                CNT_W    = width_for(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] stable_cnt;
   logic             level_d;

   // Synchronizer resets to the released value so that reset itself can
   // never look like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= raw_n;
         sync_2 <= sync_1;
      end
   end

   // stable_cnt counts consecutive samples that disagree with level; any
   // agreeing sample restarts the count, so bounces shorter than
   // DEBOUNCE_CYCLES never move the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level      <= 1'b1;
         stable_cnt <= '0;
      end else if (sync_2 == level) begin
         stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
         level      <= sync_2;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

   // Registered falling-edge detect of the debounced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b1;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level_d & ~level;
      end
   end

endmodule

// File: rtl/cell_byte_feeder.sv
// cell_byte_feeder
//   Feeds vga_controller one display cell per accepted button press (or a
//   whole screen per press in burst mode) by reading successive bytes from
//   port B of the character RAM.
//   Ports:
//     clk        in  1           50 MHz system clock
//     rst        in  1           asynchronous, active-high reset
//     btn_n      in  1           raw push-button, active-low, asynchronous
//     burst      in  1           sampled on the accepted press:
//                                1 = CELL_COUNT bytes, 0 = one byte
//     q_b        in  8           RAM port B read data
//     address_b  out ADDR_WIDTH  RAM port B read address
//     byte_out   out 8           byte presented to the controller
//     byte_valid out 1           single-cycle write strobe
//     busy       out 1           FSM is not IDLE
//     state_dbg  out 2           current FSM state, for observation only
//   Strobe semantics: byte_valid is a one-cycle strobe with no ready/back-
//   pressure; byte_out is meaningful exactly in the cycle byte_valid is high
//   and the consumer must take it in that cycle.
//   Latency: press in cycle T -> READ in T+1..T+1+RAM_LATENCY -> strobe in
//   T+2+RAM_LATENCY; burst strobes repeat every RAM_LATENCY+2 cycles.
module cell_byte_feeder
   import cell_feeder_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
   parameter int ADDR_WIDTH      = 8,
   parameter int RAM_DEPTH       = 256,
   parameter int RAM_LATENCY     = 2,
   parameter int CELL_COUNT      = CELL_COUNT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_n,
   input  logic                  burst,
   input  logic [7:0]            q_b,
   output logic [ADDR_WIDTH-1:0] address_b,
   output logic [7:0]            byte_out,
   output logic                  byte_valid,
   output logic                  busy,
   output feeder_state_t         state_dbg
);

   localparam int                    REM_W     = $clog2(CELL_COUNT + 1);
   localparam int                    LAT_W     = width_for(RAM_LATENCY);
   localparam logic [REM_W-1:0]      REM_BURST = REM_W'(CELL_COUNT);
   localparam logic [REM_W-1:0]      REM_ONE   = REM_W'(1);
   localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RAM_LATENCY);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

   feeder_state_t    state;
   feeder_state_t    state_next;
   logic             press;
   logic             level_unused;
   logic [REM_W-1:0] remaining;
   logic [REM_W-1:0] rem_dec;
   logic [LAT_W-1:0] lat_cnt;
   logic             load_op;
   logic             lat_step;
   logic             capture;
   logic             advance;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk   (clk),
      .rst   (rst),
      .raw_n (btn_n),
      .level (level_unused),
      .press (press)
   );

   assign rem_dec   = remaining - 1'b1;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-cycle control. byte_valid comes straight from the
   // state register, so an asynchronous reset removes it in the same cycle.
   always_comb begin
      state_next = state;
      load_op    = 1'b0;
      lat_step   = 1'b0;
      capture    = 1'b0;
      advance    = 1'b0;
      byte_valid = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               load_op    = 1'b1;
               state_next = READ;
            end
         end
         READ: begin
            // Address is held for RAM_LATENCY+1 cycles; the last one sees
            // valid q_b and captures it.
            if (lat_cnt == LAT_LAST) begin
               capture    = 1'b1;
               state_next = EMIT;
            end else begin
               lat_step = 1'b1;
            end
         end
         EMIT: begin
            byte_valid = 1'b1;
            advance    = 1'b1;
            state_next = (rem_dec == '0) ? IDLE : READ;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath. The address is never cleared between operations so that
   // each new press continues where the previous one stopped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address_b <= '0;
         byte_out  <= '0;
         remaining <= '0;
         lat_cnt   <= '0;
      end else begin
         if (load_op) begin
            remaining <= burst ? REM_BURST : REM_ONE;
         end else if (advance) begin
            remaining <= rem_dec;
         end

         if (capture) begin
            byte_out <= q_b;
            lat_cnt  <= '0;
         end else if (lat_step) begin
            lat_cnt <= lat_cnt + 1'b1;
         end

         // Explicit wrap so RAM_DEPTH need not be a power of two.
         if (advance) begin
            address_b <= (address_b == ADDR_LAST) ? '0 : address_b + 1'b1;
         end
      end
   end

endmodule

// File: doc/cell_byte_feeder.md
# cell_byte_feeder

Upstream source for `vga_controller`. It turns a raw push-button into clean single-cycle write strobes, and reads successive bytes from port B of the character dual-port RAM. Its `byte_out`/`byte_valid` pair drives the controller's `q_b`/`button` inputs, so each accepted press (or each burst step) fills exactly one display cell. It runs on the 50 MHz system clock, the same domain as the controller's cell-array write logic.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `DEBOUNCE_CYCLES`, `CLK_HZ/100` (10 ms): stable-input cycles required to accept a level change. Must be ≥1.
- `ADDR_WIDTH`, 8: RAM port B address width.
- `RAM_DEPTH`, 256: number of readable words; the address wraps at `RAM_DEPTH-1`. Must be ≤ 2^ADDR_WIDTH.
- `RAM_LATENCY`, 2: cycles from `address_b` change to valid `q_b`. Must be ≥1.
- `CELL_COUNT`, 720: bytes per burst (36×20 cells).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_n`, in, 1: raw push-button, active-low, asynchronous to `clk`.
- `burst`, in, 1: sampled on the accepted press. 1 = stream `CELL_COUNT` bytes; 0 = a single byte.
- `q_b`, in, 8: RAM port B read data.
- `address_b`, out, ADDR_WIDTH: RAM port B read address.
- `byte_out`, out, 8: byte presented to the controller.
- `byte_valid`, out, 1: single-cycle write strobe.
- `busy`, out, 1: high whenever the FSM is not IDLE.

## Operation
- Input conditioning: `btn_n` passes through a 2-flop synchronizer, then the debouncer.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples that differ from it.
  - Any sample equal to the current level clears the counter.
  - A press is a 1→0 transition of the debounced level. It produces `press` high for exactly one cycle.
- FSM states and transitions:
  - IDLE: on `press`, latch `remaining = burst ? CELL_COUNT : 1` and go to READ.
  - READ: hold `address_b` constant for RAM_LATENCY+1 cycles. On the last READ cycle register `byte_out <= q_b`, then go to EMIT.
  - EMIT: `byte_valid = 1` for one cycle. `address_b` increments, with the wrap `RAM_DEPTH-1 → 0`. `remaining` decrements. If the new `remaining` is 0, go to IDLE; otherwise go to READ.
- Presses while `busy` are discarded, not queued.
- A release/re-press that fails to stay stable for `DEBOUNCE_CYCLES` produces no press.
- `address_b` persists across operations: the next press continues from the last address + 1.
- `remaining` is `$clog2(CELL_COUNT+1)` bits wide. `address_b` arithmetic is modulo `RAM_DEPTH`, using an explicit compare, not a power-of-two truncation.

## Timing
- Reset values: `address_b=0`, `byte_out=0`, `byte_valid=0`, `busy=0`, state IDLE. The debounced level resets to 1 (released), and the synchronizer flops reset to 1.
- If `press` is high in cycle T, READ spans T+1 … T+1+RAM_LATENCY and `byte_valid` is high in cycle T+2+RAM_LATENCY. With the default `RAM_LATENCY=2`, that is T+4.
- In a burst, strobes occur every RAM_LATENCY+2 cycles (4 by default), with `byte_out` stable from its capture through the strobe cycle.
- Raw `btn_n` fall to `press`: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 edge cycle.
- `busy` rises in T+1 and falls in the cycle after the final EMIT.
- `rst` asserted mid-burst aborts immediately: `byte_valid` drops the same cycle, outputs go to their reset values, and no partial strobe is produced.
- `press` coinciding with the final EMIT is discarded, because the state is not yet IDLE.

## Structure
- Package `cell_feeder_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, READ, EMIT} feeder_state_t`.
  - Constants `CELLS_H=36`, `CELLS_V=20`, `CELL_COUNT_DEFAULT=CELLS_H*CELLS_V`.
- Sub-module `button_debouncer` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `raw_n`, `level`, `press`) contains the synchronizer, the stable counter and the edge detector.
- The top level holds the FSM, the latency counter, the address and the remaining counter.

## Test plan
Common setup: `DEBOUNCE_CYCLES=4`, `RAM_LATENCY=2`, `RAM_DEPTH=8`, `CELL_COUNT=10`. The RAM model returns `8'hA0+address` with a 2-cycle delay.

- Single press, `burst=0` → exactly one `byte_valid` with `byte_out=8'hA0`, 4 cycles after `press`. Then `address_b=1` and `busy=0`.
- Bounce: `btn_n` toggles every 2 cycles for 20 cycles, then is held low → exactly one `press`, 7 cycles after the hold begins.
- Press with `burst=1` → 10 strobes spaced 4 cycles apart carrying A0..A7,A0,A1 (address wraps 7→0). A second press mid-burst is ignored.
- `rst` pulsed after the 3rd burst strobe → `byte_valid` drops immediately, no further strobes occur, and `address_b=0`, `busy=0`.
- Press at the final EMIT cycle → no new operation starts. The next press after IDLE resumes from the next address.
